// File: rtl/fifo_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_dispatcher_pkg
//  Brief    : Shared state encodings and width helper for the FIFO dispatcher.
//  Revision : 1.0
// ============================================================================
package fifo_dispatcher_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_POP     = 2'd1;
    localparam state_t S_WAIT    = 2'd2;
    localparam state_t S_DELIVER = 2'd3;

    // Index width for a requester vector; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_dispatcher_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_dispatcher_rr_picker
//  Brief    : Combinational round-robin picker: first set request at or above
//             the pointer, wrapping past the top index.
//  Revision : 1.0
// ============================================================================
module fifo_dispatcher_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W:0]       w_off;
    logic [IDX_W:0]       w_sum;

    always_comb begin
        // Rotating a doubled copy puts the pointer position at bit 0.
        w_dbl   = {i_req, i_req};
        w_rot   = NUM_REQ'(w_dbl >> i_ptr);
        w_off   = '0;
        o_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_found = 1'b1;
                w_off   = (IDX_W + 1)'(i);
            end
        end
        w_sum = {1'b0, i_ptr} + w_off;
        if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
        end
        o_idx = w_sum[IDX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/fifo_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_dispatcher
//  Brief    : Drains the shared byte FIFO and hands each byte to one of
//             NUM_READERS consumers, chosen round-robin, held until acked.
//  Revision : 1.0
// ============================================================================
module fifo_dispatcher
    import fifo_dispatcher_pkg::*;
#(
    parameter int NUM_READERS = 2,
    parameter int DATA_W      = 8
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_fifo_empty,
    input  logic [DATA_W-1:0]                  i_fifo_data,
    output logic                               o_fifo_re,
    input  logic [NUM_READERS-1:0]             i_req,
    input  logic [NUM_READERS-1:0]             i_ack,
    output logic [NUM_READERS-1:0]             o_valid,
    output logic [DATA_W-1:0]                  o_data,
    output logic [grant_w(NUM_READERS)-1:0]    o_grant_id
);

    localparam int c_grant_w = grant_w(NUM_READERS);
    localparam logic [c_grant_w-1:0]   c_last = c_grant_w'(NUM_READERS - 1);
    localparam logic [NUM_READERS-1:0] c_one  = NUM_READERS'(1);

    state_t                  r_state;
    logic [c_grant_w-1:0]    r_ptr;
    logic [c_grant_w-1:0]    r_grant;
    logic [NUM_READERS-1:0]  r_valid;
    logic [DATA_W-1:0]       r_data;
    logic                    r_fifo_re;

    logic [c_grant_w-1:0]    w_idx;
    logic                    w_found;
    logic [c_grant_w-1:0]    w_ptr_next;

    fifo_dispatcher_rr_picker #(
        .NUM_REQ (NUM_READERS),
        .IDX_W   (c_grant_w)
    ) u_picker (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    assign w_ptr_next = (r_grant == c_last) ? '0 : r_grant + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_valid   <= '0;
            r_data    <= '0;
            r_fifo_re <= 1'b0;
        end else begin
            r_fifo_re <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && !i_fifo_empty) begin
                        r_grant   <= w_idx;
                        r_fifo_re <= 1'b1;
                        r_state   <= S_POP;
                    end
                end
                S_POP: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // FIFO read data is valid now, one cycle after the pop.
                    r_data  <= i_fifo_data;
                    r_valid <= c_one << r_grant;
                    r_state <= S_DELIVER;
                end
                S_DELIVER: begin
                    // r_valid is one-hot on the grant, so this masks foreign acks.
                    if (|(i_ack & r_valid)) begin
                        r_valid <= '0;
                        r_ptr   <= w_ptr_next;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_fifo_re  = r_fifo_re;
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_grant_id = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_fifo_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_dispatcher
//  Brief    : Directed bench for fifo_dispatcher (2-reader and 3-reader).
//  Revision : 1.0
// ============================================================================
module tb_fifo_dispatcher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] ack = 2'b00;
    logic [1:0] valid;
    logic       re;
    logic [7:0] data;
    logic       gid;
    logic       empty;
    logic [7:0] fdata = 8'h00;

    logic [2:0] req3 = 3'b000;
    logic [2:0] ack3 = 3'b000;
    logic [2:0] valid3;
    logic       re3;
    logic [7:0] data3;
    logic [1:0] gid3;
    logic       empty3 = 1'b0;
    logic [7:0] fdata3 = 8'h99;

    logic [7:0] mem [0:15];
    int         wr_cnt = 0;
    int         rd_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after the pop strobe.
    assign empty = (wr_cnt == rd_cnt);
    always @(posedge clk) begin
        if (re && (rd_cnt < wr_cnt)) begin
            fdata  <= mem[rd_cnt[3:0]];
            rd_cnt <= rd_cnt + 1;
        end
    end

    fifo_dispatcher #(.NUM_READERS(2), .DATA_W(8)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_fifo_empty (empty),
        .i_fifo_data  (fdata),
        .o_fifo_re    (re),
        .i_req        (req),
        .i_ack        (ack),
        .o_valid      (valid),
        .o_data       (data),
        .o_grant_id   (gid)
    );

    fifo_dispatcher #(.NUM_READERS(3), .DATA_W(8)) dut3 (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_fifo_empty (empty3),
        .i_fifo_data  (fdata3),
        .o_fifo_re    (re3),
        .i_req        (req3),
        .i_ack        (ack3),
        .o_valid      (valid3),
        .o_data       (data3),
        .o_grant_id   (gid3)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] ack;
        logic [1:0] valid;
        logic       re;
        logic [7:0] data;
        logic       gid;
    } vec_t;

    vec_t vecs [19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_cnt[3:0]] = b;
        wr_cnt++;
    endtask

    initial begin
        // Single request (0..4), reset (5), contention 0,1,0 (6..17), idle (18)
        vecs[0]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 8'hA5, 1'b0};
        vecs[3]  = '{1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 8'hA5, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 8'hA5, 1'b0};
        vecs[5]  = '{1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 8'h11, 1'b0};
        vecs[9]  = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b0, 8'h11, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 8'h11, 1'b1};
        vecs[11] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 8'h11, 1'b1};
        vecs[12] = '{1'b0, 2'b11, 2'b00, 2'b10, 1'b0, 8'h22, 1'b1};
        vecs[13] = '{1'b0, 2'b11, 2'b10, 2'b00, 1'b0, 8'h22, 1'b1};
        vecs[14] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 8'h22, 1'b0};
        vecs[15] = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 8'h22, 1'b0};
        vecs[16] = '{1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 8'h33, 1'b0};
        vecs[17] = '{1'b0, 2'b11, 2'b01, 2'b00, 1'b0, 8'h33, 1'b0};
        vecs[18] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 8'h33, 1'b0};

        push(8'hA5); push(8'h11); push(8'h22); push(8'h33);
        rst = 1'b1;
        tick(); tick();
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_re",    32'(re),    32'h0);
        chk("reset_data",  32'(data),  32'h0);
        chk("reset_gid",   32'(gid),   32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 19; i++) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            ack = vecs[i].ack;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_re", i),    32'(re),    32'(vecs[i].re));
            chk($sformatf("vec%0d_data", i),  32'(data),  32'(vecs[i].data));
            chk($sformatf("vec%0d_gid", i),   32'(gid),   32'(vecs[i].gid));
        end
        rst = 1'b0; req = 2'b00; ack = 2'b00;

        // Empty FIFO: reader 1 waits, nothing is popped.
        req = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("empty_re",    32'(re),    32'h0);
            chk("empty_valid", 32'(valid), 32'h0);
        end
        push(8'h7E);
        tick();
        chk("empty_pop_re", 32'(re), 32'h1);
        tick();
        tick();
        chk("empty_valid1", 32'(valid), 32'h2);
        chk("empty_data",   32'(data),  32'h7E);
        chk("empty_gid",    32'(gid),   32'h1);
        req = 2'b00; ack = 2'b10;
        tick();
        chk("empty_ack_valid", 32'(valid), 32'h0);
        ack = 2'b00;

        // Late ack with request drop; wrong-bit ack ignored.
        push(8'h5C);
        req = 2'b01;
        tick();
        chk("late_re",  32'(re),  32'h1);
        chk("late_gid", 32'(gid), 32'h0);
        tick();
        req = 2'b00;
        tick();
        chk("late_valid0", 32'(valid), 32'h1);
        chk("late_data0",  32'(data),  32'h5C);
        for (int i = 1; i < 5; i++) begin
            ack = 2'b10;
            tick();
            chk($sformatf("late_valid%0d", i), 32'(valid), 32'h1);
            chk($sformatf("late_data%0d", i),  32'(data),  32'h5C);
        end
        ack = 2'b01;
        tick();
        chk("late_ack_valid", 32'(valid), 32'h0);
        ack = 2'b00;

        // Reset during WAIT discards the popped byte; reader 0 regains priority.
        push(8'h3C);
        req = 2'b01;
        tick();
        chk("rstop_re", 32'(re), 32'h1);
        tick();
        req = 2'b00;
        rst = 1'b1;
        tick();
        chk("rstop_valid", 32'(valid), 32'h0);
        chk("rstop_re0",   32'(re),    32'h0);
        chk("rstop_data",  32'(data),  32'h0);
        chk("rstop_gid",   32'(gid),   32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstop_no_valid", 32'(valid), 32'h0);
            chk("rstop_no_data",  32'(data),  32'h0);
        end
        push(8'h4D);
        req = 2'b11;
        tick();
        chk("rstop_prio_re",  32'(re),  32'h1);
        chk("rstop_prio_gid", 32'(gid), 32'h0);
        tick();
        tick();
        chk("rstop_prio_valid", 32'(valid), 32'h1);
        chk("rstop_prio_data",  32'(data),  32'h4D);
        req = 2'b00; ack = 2'b01;
        tick();
        ack = 2'b00;

        // Three readers: move pointer to 2, then wrap to reader 0.
        req3 = 3'b010;
        tick();
        chk("n3_re",   32'(re3),  32'h1);
        chk("n3_gid1", 32'(gid3), 32'h1);
        tick();
        tick();
        chk("n3_valid1", 32'(valid3), 32'h2);
        chk("n3_data",   32'(data3),  32'h99);
        req3 = 3'b000; ack3 = 3'b010;
        tick();
        ack3 = 3'b000;
        req3 = 3'b011;
        tick();
        chk("n3_wrap_gid", 32'(gid3), 32'h0);
        tick();
        tick();
        chk("n3_wrap_valid", 32'(valid3), 32'h1);
        ack3 = 3'b001;
        tick();
        chk("n3_ack_valid", 32'(valid3), 32'h0);
        ack3 = 3'b000;
        tick();
        chk("n3_ptr1_gid", 32'(gid3), 32'h1);
        req3 = 3'b000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // One-hot-or-zero valid and no back-to-back pops, sampled away from the edge.
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(valid) > 1 || $countones(valid3) > 1) begin
                n_errors++;
                $display("FAIL onehot_valid: got %0h/%0h expected at most one bit", valid, valid3);
            end
        end
    end

    logic re_d = 1'b0;
    always @(posedge clk) begin
        re_d <= re;
        if (re && re_d) begin
            $display("FAIL pop_pulse: got two consecutive pops expected one-cycle strobe");
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_dispatcher.md
Name: fifo_dispatcher

Overview:
Read-side counterpart of the write arbiter: drains the shared byte FIFO and hands each byte to exactly one of NUM_READERS consumer modules. Consumers raise a request line. The dispatcher picks one requester round-robin, pops the FIFO and presents the byte on a shared data bus. The byte is held until the chosen consumer acknowledges it. Sits between the FIFO read port and the reader modules.

Parameters:
NUM_READERS, 2, number of consumer modules; must be at least 2.
DATA_W, 8, byte width of the FIFO and the output bus.

Ports:
i_clk  in  1  system clock.
i_reset  in  1  synchronous, active-high reset.
i_fifo_empty  in  1  FIFO empty flag.
i_fifo_data  in  DATA_W  FIFO read data; valid the cycle after o_fifo_re.
o_fifo_re  out  1  FIFO pop strobe; one cycle wide.
i_req  in  NUM_READERS  per-reader request for a byte.
i_ack  in  NUM_READERS  per-reader acknowledge of the presented byte.
o_valid  out  NUM_READERS  one-hot-or-zero; byte on o_data is for this reader.
o_data  out  DATA_W  shared data bus to readers.
o_grant_id  out  $clog2(NUM_READERS)  index of the current or last granted reader.

Behaviour:
- Reset (i_reset sampled high at a posedge):
  - outputs: o_valid=0, o_fifo_re=0, o_data=0, o_grant_id=0.
  - state: state=IDLE, round-robin pointer=0 (reader 0 has highest priority).
- Reset wins over every other event. Reset mid-transaction discards any popped byte; no o_valid follows it.
- States: IDLE, POP, WAIT, DELIVER. All outputs are registered.
- IDLE:
  - Leaves only if (|i_req) && !i_fifo_empty.
  - Grant = first set bit of i_req, searching from pointer upward and wrapping at NUM_READERS-1 -> 0.
  - Latches grant into o_grant_id, goes to POP.
- POP: o_fifo_re=1 for exactly this cycle. Next state WAIT.
- WAIT: o_fifo_re=0. At the end of WAIT, i_fifo_data is captured into o_data. Next state DELIVER.
- DELIVER:
  - o_valid[o_grant_id]=1 and o_data is stable for the whole state.
  - i_ack[o_grant_id] high completes the transfer at that edge: o_valid->0, pointer = grant+1 (wrap to 0 past NUM_READERS-1), state IDLE.
  - i_ack on any other bit is ignored.
- Latency: request plus non-empty seen at edge k gives o_fifo_re high in cycle k+1 and o_valid high in cycle k+3. Best-case throughput is one byte per 4 cycles. The new request is evaluated in IDLE the cycle after the ack.
- Request drop after grant: the byte is already committed. o_valid stays high until acked, even if i_req[grant] falls.
- Empty FIFO: never pop while i_fifo_empty=1. The flag is sampled only in IDLE.
- Simultaneous requests: exactly one is served per byte. Round-robin guarantees each persistent requester is served within NUM_READERS transfers.
- Invariants:
  - $countones(o_valid) <= 1.
  - o_fifo_re is never high in two consecutive cycles.
  - o_valid=0 outside DELIVER.
  - o_data changes only at the WAIT->DELIVER edge or reset.

Decomposition:
- Shared package: state enum (IDLE/POP/WAIT/DELIVER, 2 bits) and a GRANT_W = $clog2(NUM_READERS) constant helper.
- Natural sub-module: rr_picker. It is combinational and takes req vector plus pointer; it returns index and found flag. It is reusable by the write arbiter for fairness.

Test Plan:
- Single request: FIFO holds 0xA5, i_req=2'b01 at cycle 0 -> o_fifo_re in cycle 1; o_valid=2'b01 and o_data=0xA5 in cycle 3, held until i_ack[0]; pointer becomes 1.
- Contention: FIFO holds 0x11,0x22,0x33, i_req=2'b11 held, acks immediate -> bytes delivered to readers 0,1,0 in order; o_valid never 2'b11.
- Empty FIFO: i_req=2'b10, i_fifo_empty=1 for 10 cycles -> o_fifo_re stays 0 and o_valid stays 0. Deassert empty with data 0x7E -> reader 1 gets 0x7E at +3 cycles.
- Late ack and request drop: reader 0 granted with data 0x5C, i_req[0] drops in WAIT, ack after 5 DELIVER cycles -> o_valid[0] and o_data=0x5C stable all 5 cycles; wrong-bit i_ack[1] during DELIVER is ignored.
- Reset mid-op: assert i_reset during WAIT -> next cycle all outputs 0 and state IDLE; the popped byte is never presented. After release, reader 0 has priority.
- NUM_READERS=3 wrap: pointer=2, i_req=3'b011 -> reader 0 granted; after ack, pointer=1.
